// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Brief  : Shared state encoding and byte-lane constants for the clearing RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_clear_dual_port_if.sv
// ============================================================================
// Module : ram_clear_dual_port_if
// Brief  : User write/read/clear bus of the self-clearing dual-port RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ram_clear_dual_port_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int c_BE_W = DATA_WIDTH / LANE_W;

    logic                  we;
    logic [c_BE_W-1:0]     be;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  re;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  clear_req;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output we, be, write_addr, data, re, read_addr, clear_req,
        input  q, q_valid, busy
    );

    modport slave (
        input  we, be, write_addr, data, re, read_addr, clear_req,
        output q, q_valid, busy
    );

endinterface

`default_nettype wire

// File: rtl/ram_clear_sequencer.sv
// ============================================================================
// Module : ram_clear_sequencer
// Brief  : Walks every address once after reset or on request, then idles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_clear_sequencer
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_clear_req,
    output logic                       o_busy,
    output logic                       o_clr_we,
    output logic [ADDR_WIDTH-1:0]      o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_LAST = '1;

    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A request arriving while clearing is dropped: the sequence neither restarts nor extends.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + c_ONE;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == ST_CLEAR);
    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_cnt;

endmodule

`default_nettype wire

// File: rtl/ram_clear_dual_port.sv
// ============================================================================
// Module : ram_clear_dual_port
// Brief  : Byte-enabled 1W/1R RAM that clears itself after reset or on request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_clear_dual_port
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 6,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter bit                    READ_BYPASS = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ram_clear_dual_port_if.slave  bus
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_BE_W  = DATA_WIDTH / LANE_W;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_q_valid;

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_BE_W-1:0]     w_wr_be;
    logic                  w_user_we;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_word;

    ram_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear_req (bus.clear_req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    // While clearing, the sequencer owns the write port and user traffic is ignored.
    assign w_user_we = bus.we & ~w_busy;
    assign w_wr_en   = w_busy ? w_clr_we    : bus.we;
    assign w_wr_addr = w_busy ? w_clr_addr  : bus.write_addr;
    assign w_wr_data = w_busy ? CLEAR_VALUE : bus.data;
    assign w_wr_be   = w_busy ? '1          : bus.be;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < c_BE_W; i++) begin
                if (w_wr_be[i]) begin
                    r_mem[w_wr_addr][i*LANE_W +: LANE_W] <= w_wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign w_rd_old = r_mem[bus.read_addr];

    generate
        if (READ_BYPASS) begin : g_bypass
            always_comb begin
                w_rd_word = w_rd_old;
                if (w_user_we && (bus.write_addr == bus.read_addr)) begin
                    for (int i = 0; i < c_BE_W; i++) begin
                        if (bus.be[i]) begin
                            w_rd_word[i*LANE_W +: LANE_W] = bus.data[i*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end else begin : g_no_bypass
            assign w_rd_word = w_rd_old;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (bus.re && !w_busy) begin
            r_q       <= w_rd_word;
            r_q_valid <= 1'b1;
        end else begin
            r_q_valid <= 1'b0;
        end
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_ram_clear_dual_port.sv
// ============================================================================
// Module : tb_ram_clear_dual_port
// Brief  : Drives a no-bypass and a bypass instance in lockstep against an array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_clear_dual_port;

    localparam int          c_DW  = 32;
    localparam int          c_AW  = 4;
    localparam int          c_N   = 16;
    localparam logic [31:0] c_CV0 = 32'h0000_0000;
    localparam logic [31:0] c_CV1 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_clear_dual_port_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) if0 ();
    ram_clear_dual_port_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) if1 ();

    ram_clear_dual_port #(
        .DATA_WIDTH (c_DW), .ADDR_WIDTH (c_AW), .CLEAR_VALUE (c_CV0), .READ_BYPASS (1'b0)
    ) dut0 (.clk (clk), .rst_n (rst_n), .bus (if0.slave));

    ram_clear_dual_port #(
        .DATA_WIDTH (c_DW), .ADDR_WIDTH (c_AW), .CLEAR_VALUE (c_CV1), .READ_BYPASS (1'b1)
    ) dut1 (.clk (clk), .rst_n (rst_n), .bus (if1.slave));

    logic [31:0] m0 [c_N];
    logic [31:0] m1 [c_N];
    logic [31:0] exp_q0 = '0;
    logic [31:0] exp_q1 = '0;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_N; i++) begin
            m0[i] = c_CV0;
            m1[i] = c_CV1;
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [3:0] wa,
                         input logic [31:0] d, input logic re, input logic [3:0] ra,
                         input logic cr);
        if0.we = we; if0.be = be; if0.write_addr = wa; if0.data = d;
        if0.re = re; if0.read_addr = ra; if0.clear_req = cr;
        if1.we = we; if1.be = be; if1.write_addr = wa; if1.data = d;
        if1.re = re; if1.read_addr = ra; if1.clear_req = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE-state cycle: expected read words come from the model before its write lands.
    task automatic op(input string tag, input logic we, input logic [3:0] be,
                      input logic [3:0] wa, input logic [31:0] d,
                      input logic re, input logic [3:0] ra);
        logic [31:0] rd0, rd1;
        rd0 = m0[ra];
        rd1 = (we && wa == ra) ? merge(m1[ra], d, be) : m1[ra];
        drive(we, be, wa, d, re, ra, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        if (re) begin
            exp_q0 = rd0;
            exp_q1 = rd1;
        end
        if (we) begin
            m0[wa] = merge(m0[wa], d, be);
            m1[wa] = merge(m1[wa], d, be);
        end
        chk({tag, "_q0"}, if0.q, exp_q0);
        chk({tag, "_q1"}, if1.q, exp_q1);
        chk({tag, "_qv0"}, {31'b0, if0.q_valid}, {31'b0, re});
        chk({tag, "_qv1"}, {31'b0, if1.q_valid}, {31'b0, re});
    endtask

    // Counts rising edges until busy drops, optionally pulsing clear_req at edge pulse_at.
    task automatic wait_clear(input int pulse_at, output int n);
        n = 0;
        while (if0.busy === 1'b1 && n < 100) begin
            if (n == pulse_at) begin
                if0.clear_req = 1'b1;
                if1.clear_req = 1'b1;
            end
            tick();
            if0.clear_req = 1'b0;
            if1.clear_req = 1'b0;
            n++;
        end
        chk("busy1_after_clear", {31'b0, if1.busy}, 32'h0);
    endtask

    initial begin
        int n;
        logic [3:0] wa, ra;

        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q0", if0.q, 32'h0);
        chk("rst_qv0", {31'b0, if0.q_valid}, 32'h0);
        chk("rst_busy0", {31'b0, if0.busy}, 32'h1);
        chk("rst_busy1", {31'b0, if1.busy}, 32'h1);

        rst_n = 1'b1;
        model_clear();
        wait_clear(-1, n);
        chk("init_clear_len", n, 16);

        for (int i = 0; i < c_N; i++) op("init_rd", 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
        op("hold", 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);

        op("bw_w1", 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
        op("bw_w2", 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0);
        op("bw_rd", 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
        chk("bw_value", if0.q, 32'hAA22CC44);

        op("byp_w", 1'b1, 4'hF, 4'd5, 32'h12, 1'b0, 4'd0);
        op("byp_rw", 1'b1, 4'hF, 4'd5, 32'h34, 1'b1, 4'd5);
        chk("byp_off", if0.q, 32'h12);
        chk("byp_on", if1.q, 32'h34);

        for (int i = 0; i < 60; i++) begin
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            op("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa,
               $urandom, 1'($urandom_range(0, 3) != 0), ra);
        end

        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("creq_busy0", {31'b0, if0.busy}, 32'h1);
        model_clear();
        drive(1'b1, 4'hF, 4'd2, 32'h55, 1'b1, 4'd2, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("creq_qv0", {31'b0, if0.q_valid}, 32'h0);
        chk("creq_qhold1", if1.q, exp_q1);
        wait_clear(-1, n);
        chk("creq_clear_len", n + 1, 16);
        op("creq_rd", 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);

        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        exp_q0 = '0;
        exp_q1 = '0;
        chk("midrst_busy0", {31'b0, if0.busy}, 32'h1);
        chk("midrst_q1", if1.q, 32'h0);
        tick();
        rst_n = 1'b1;
        model_clear();
        wait_clear(5, n);
        chk("midrst_clear_len", n, 16);
        op("post_rd", 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
